// File: rtl/axi_mem_arbiter.sv
// axi_mem_arbiter: round-robin arbiter over NUM_PORTS single-word memory
// ports, issuing one single-beat AXI3 transaction at a time.
module axi_mem_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int ID_W      = 4,
    parameter int ID_BASE   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_PORTS-1:0]    req_en,
    input  logic [4*NUM_PORTS-1:0]  req_wen,
    input  logic [32*NUM_PORTS-1:0] req_addr,
    input  logic [32*NUM_PORTS-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]    resp_valid,
    output logic                    resp_err,
    output logic [31:0]             resp_rdata,
    output logic                    stall_all,
    output logic [ID_W-1:0]         arid,
    output logic [31:0]             araddr,
    output logic [3:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [ID_W-1:0]         rid,
    input  logic [31:0]             rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready,
    output logic [ID_W-1:0]         awid,
    output logic [31:0]             awaddr,
    output logic [3:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [ID_W-1:0]         wid,
    output logic [31:0]             wdata,
    output logic [3:0]              wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [ID_W-1:0]         bid,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready
);

    localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [2:0] {IDLE, AR, R, WR, B, DONE} state_t;

    state_t         state;
    logic [IW-1:0]  ptr;
    logic [IW-1:0]  gnt;
    logic [IW-1:0]  win;
    logic [IW-1:0]  idx;
    logic [ID_W-1:0] gid;
    logic [3:0]     g_wen;
    logic [31:0]    g_addr;
    logic [31:0]    g_wdata;
    logic [3:0]     sel_wen;
    logic [31:0]    sel_addr;
    logic [31:0]    sel_wdata;
    logic           unused;
    int             c;

    assign unused = ^{rid, bid};

    // Walk downwards so the last hit is the first requester after ptr.
    always_comb begin
        win = ptr;
        idx = '0;
        c   = 0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            c = int'(ptr) + k;
            if (c >= NUM_PORTS) c = c - NUM_PORTS;
            idx = IW'(c);
            if (req_en[idx]) win = idx;
        end
    end

    always_comb begin
        sel_wen   = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (win == IW'(i)) begin
                sel_wen   = req_wen[i*4 +: 4];
                sel_addr  = req_addr[i*32 +: 32];
                sel_wdata = req_wdata[i*32 +: 32];
            end
        end
    end

    assign stall_all = |(req_en & ~resp_valid);

    assign arid    = gid;
    assign araddr  = g_addr;
    assign arlen   = 4'd0;
    assign arsize  = 3'b010;
    assign arburst = 2'b01;
    assign awid    = gid;
    assign awaddr  = g_addr;
    assign awlen   = 4'd0;
    assign awsize  = 3'b010;
    assign awburst = 2'b01;
    assign wid     = gid;
    assign wdata   = g_wdata;
    assign wstrb   = g_wen;
    assign wlast   = 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= IW'(NUM_PORTS - 1);
            gnt        <= '0;
            gid        <= '0;
            g_wen      <= '0;
            g_addr     <= '0;
            g_wdata    <= '0;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            awvalid    <= 1'b0;
            wvalid     <= 1'b0;
            bready     <= 1'b0;
            resp_valid <= '0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|req_en) begin
                        ptr     <= win;
                        gnt     <= win;
                        gid     <= ID_W'(ID_BASE + int'(win));
                        g_wen   <= sel_wen;
                        g_addr  <= sel_addr;
                        g_wdata <= sel_wdata;
                        if (sel_wen == 4'd0) begin
                            arvalid <= 1'b1;
                            state   <= AR;
                        end else begin
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state   <= WR;
                        end
                    end
                end
                AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= R;
                    end
                end
                R: begin
                    if (rvalid) begin
                        resp_rdata <= rdata;
                        resp_err   <= |rresp;
                        if (rlast) begin
                            rready     <= 1'b0;
                            resp_valid <= NUM_PORTS'(1) << gnt;
                            state      <= DONE;
                        end
                    end
                end
                WR: begin
                    if (awready) awvalid <= 1'b0;
                    if (wready) wvalid <= 1'b0;
                    // Either channel may already be done from an earlier cycle.
                    if ((awready || !awvalid) && (wready || !wvalid)) begin
                        bready <= 1'b1;
                        state  <= B;
                    end
                end
                B: begin
                    if (bvalid) begin
                        resp_err   <= |bresp;
                        bready     <= 1'b0;
                        resp_valid <= NUM_PORTS'(1) << gnt;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    resp_valid <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// tb_axi_mem_arbiter: directed bench with a small AXI3 slave model,
// four ports and an ID base that wraps the 4-bit ID field.
module tb_axi_mem_arbiter;

    localparam int NP = 4;
    localparam int IDW = 4;
    localparam int IDB = 13;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NP-1:0] req_en = '0;
    logic [4*NP-1:0]  req_wen = '0;
    logic [32*NP-1:0] req_addr = '0;
    logic [32*NP-1:0] req_wdata = '0;
    logic [NP-1:0] resp_valid;
    logic          resp_err;
    logic [31:0]   resp_rdata;
    logic          stall_all;
    logic [IDW-1:0] arid, rid, awid, wid, bid;
    logic [31:0]   araddr, rdata, awaddr, wdata;
    logic [3:0]    arlen, awlen, wstrb;
    logic [2:0]    arsize, awsize;
    logic [1:0]    arburst, awburst, rresp, bresp;
    logic          arvalid, arready, rlast, rvalid, rready;
    logic          awvalid, awready, wlast, wvalid, wready;
    logic          bvalid, bready;

    // slave model controls
    int            aw_delay = 0;
    logic          two_beat = 1'b0;
    logic [31:0]   rdata_v = '0;
    logic [1:0]    rresp_v = '0;
    logic [1:0]    bresp_v = '0;

    int            rbeats;
    int            aw_cnt;
    logic          aw_got, w_got;
    logic [IDW-1:0] last_arid, last_awid;
    logic [31:0]   last_araddr, last_awaddr, last_wdata;
    logic [3:0]    last_wstrb;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    axi_mem_arbiter #(.NUM_PORTS(NP), .ID_W(IDW), .ID_BASE(IDB)) dut (
        .clk(clk), .rst(rst),
        .req_en(req_en), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err),
        .resp_rdata(resp_rdata), .stall_all(stall_all),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    assign arready = 1'b1;
    assign wready  = 1'b1;
    assign awready = awvalid && (aw_cnt >= aw_delay);
    assign rvalid  = (rbeats != 0);
    assign rlast   = (rbeats == 1);
    assign rdata   = (rbeats == 1) ? rdata_v : 32'hDEAD_0001;
    assign rresp   = rresp_v;
    assign rid     = last_arid;
    assign bid     = last_awid;
    assign bresp   = bresp_v;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rbeats <= 0;
            aw_cnt <= 0;
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            bvalid <= 1'b0;
            last_arid <= '0;
            last_awid <= '0;
            last_araddr <= '0;
            last_awaddr <= '0;
            last_wdata <= '0;
            last_wstrb <= '0;
        end else begin
            if (arvalid && arready) begin
                rbeats <= two_beat ? 2 : 1;
                last_arid <= arid;
                last_araddr <= araddr;
            end else if (rvalid && rready) begin
                rbeats <= rbeats - 1;
            end
            if (awvalid && !awready) aw_cnt <= aw_cnt + 1;
            else aw_cnt <= 0;
            if (awvalid && awready) begin
                last_awid <= awid;
                last_awaddr <= awaddr;
            end
            if (wvalid && wready) begin
                last_wdata <= wdata;
                last_wstrb <= wstrb;
            end
            if ((aw_got || (awvalid && awready)) &&
                (w_got || (wvalid && wready))) begin
                bvalid <= 1'b1;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end else begin
                if (awvalid && awready) aw_got <= 1'b1;
                if (wvalid && wready) w_got <= 1'b1;
            end
            if (bvalid && bready) bvalid <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic setp(input int p, input logic [3:0] wen,
                        input logic [31:0] addr, input logic [31:0] wd);
        req_wen[p*4 +: 4]    = wen;
        req_addr[p*32 +: 32] = addr;
        req_wdata[p*32 +: 32] = wd;
    endtask

    task automatic wait_resp(input int max, output logic [NP-1:0] got,
                             output int cyc);
        got = '0;
        cyc = 0;
        for (int i = 1; i <= max; i++) begin
            tick(1);
            if (resp_valid != 0) begin
                got = resp_valid;
                cyc = i;
                break;
            end
        end
        if (cyc == 0) begin
            n_chk++;
            n_bad++;
            $display("FAIL resp_timeout: got none expected pulse");
        end
    endtask

    logic [NP-1:0] got;
    int cyc;

    initial begin
        #1;
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_bready", bready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_stall", stall_all, 0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);

        // 1: port 0 read, zero-wait
        rdata_v = 32'h1234_5678;
        setp(0, 4'h0, 32'hBFC0_0000, 32'h0);
        req_en = 4'b0001;
        #1 chk("t1_stall_req", stall_all, 1);
        tick(1);
        chk("t1_arvalid", arvalid, 1);
        chk("t1_araddr", araddr, 32'hBFC0_0000);
        chk("t1_arid", arid, IDB);
        chk("t1_arsize", {arlen, arsize, arburst}, {4'd0, 3'b010, 2'b01});
        tick(1);
        chk("t1_r_rready", rready, 1);
        chk("t1_r_arvalid", arvalid, 0);
        chk("t1_r_resp", resp_valid, 0);
        tick(1);
        chk("t1_resp", resp_valid, 4'b0001);
        chk("t1_rdata", resp_rdata, 32'h1234_5678);
        chk("t1_err", resp_err, 0);
        chk("t1_stall_done", stall_all, 0);
        req_en = '0;
        tick(1);
        chk("t1_pulse_end", resp_valid, 0);

        // 2: port 1 write, awready two cycles late
        aw_delay = 2;
        setp(1, 4'b0011, 32'h8000_0010, 32'hAABB_CCDD);
        req_en = 4'b0010;
        tick(1);
        chk("t2_awvalid0", awvalid, 1);
        chk("t2_wvalid0", wvalid, 1);
        chk("t2_awaddr", awaddr, 32'h8000_0010);
        chk("t2_wstrb", wstrb, 4'b0011);
        chk("t2_wdata", wdata, 32'hAABB_CCDD);
        chk("t2_awid", awid, IDB + 1);
        chk("t2_wid", wid, IDB + 1);
        chk("t2_wlast", wlast, 1);
        tick(1);
        chk("t2_wvalid1", wvalid, 0);
        chk("t2_awvalid1", awvalid, 1);
        chk("t2_bready1", bready, 0);
        tick(1);
        chk("t2_awvalid2", awvalid, 1);
        chk("t2_bready2", bready, 0);
        tick(1);
        chk("t2_awvalid3", awvalid, 0);
        chk("t2_bready3", bready, 1);
        tick(1);
        chk("t2_resp", resp_valid, 4'b0010);
        chk("t2_err", resp_err, 0);
        chk("t2_slave_wdata", last_wdata, 32'hAABB_CCDD);
        req_en = '0;
        aw_delay = 0;
        tick(1);

        // 3: ports 0 and 1 both request continuously
        setp(1, 4'h0, 32'h1000_0004, 32'h0);
        req_en = 4'b0011;
        for (int t = 0; t < 4; t++) begin
            got = '0;
            for (int i = 1; i <= 10 && got == 0; i++) begin
                tick(1);
                chk("t3_stall", stall_all, 1);
                if (resp_valid != 0) got = resp_valid;
            end
            chk("t3_grant", got, (t % 2 == 0) ? 4'b0001 : 4'b0010);
            chk("t3_arid", last_arid, (t % 2 == 0) ? 13 : 14);
            chk("t3_araddr", last_araddr,
                (t % 2 == 0) ? 32'hBFC0_0000 : 32'h1000_0004);
        end
        req_en = '0;
        tick(1);

        // 4: error responses and a two-beat read
        rresp_v = 2'b10;
        rdata_v = 32'h0BAD_0BAD;
        req_en = 4'b0001;
        wait_resp(10, got, cyc);
        chk("t4_rd_resp", got, 4'b0001);
        chk("t4_rd_lat", cyc, 3);
        chk("t4_rd_err", resp_err, 1);
        req_en = '0;
        rresp_v = 2'b00;
        tick(1);
        bresp_v = 2'b11;
        setp(0, 4'hF, 32'hBFC0_0020, 32'h55AA_55AA);
        req_en = 4'b0001;
        wait_resp(10, got, cyc);
        chk("t4_wr_resp", got, 4'b0001);
        chk("t4_wr_lat", cyc, 3);
        chk("t4_wr_err", resp_err, 1);
        chk("t4_wr_strb", last_wstrb, 4'hF);
        chk("t4_rdata_held", resp_rdata, 32'h0BAD_0BAD);
        req_en = '0;
        bresp_v = 2'b00;
        tick(1);
        two_beat = 1'b1;
        rdata_v = 32'hCAFE_F00D;
        setp(0, 4'h0, 32'hBFC0_0040, 32'h0);
        req_en = 4'b0001;
        wait_resp(10, got, cyc);
        chk("t4_2b_resp", got, 4'b0001);
        chk("t4_2b_lat", cyc, 4);
        chk("t4_2b_rdata", resp_rdata, 32'hCAFE_F00D);
        chk("t4_2b_err", resp_err, 0);
        req_en = '0;
        two_beat = 1'b0;
        tick(1);

        // 5: reset while in R with rvalid pending
        rdata_v = 32'h7777_0000;
        req_en = 4'b0001;
        tick(2);
        chk("t5_in_r", rready, 1);
        chk("t5_rvalid_up", rvalid, 1);
        #2 rst = 1'b1;
        #1;
        chk("t5_arvalid", arvalid, 0);
        chk("t5_rready", rready, 0);
        chk("t5_awvalid", awvalid, 0);
        chk("t5_wvalid", wvalid, 0);
        chk("t5_bready", bready, 0);
        chk("t5_resp", resp_valid, 0);
        chk("t5_rdata", resp_rdata, 0);
        @(negedge clk);
        rst = 1'b0;
        req_en = 4'b0011;
        tick(1);
        chk("t5_arvalid_after", arvalid, 1);
        chk("t5_arid_after", arid, IDB);
        wait_resp(10, got, cyc);
        chk("t5_first_grant", got, 4'b0001);
        req_en = '0;
        tick(1);

        // 6: pointer at 1, ports 1 and 3 request
        setp(1, 4'h0, 32'h1000_0004, 32'h0);
        setp(3, 4'h0, 32'h2000_0008, 32'h0);
        req_en = 4'b0010;
        wait_resp(10, got, cyc);
        chk("t6_p1_setup", got, 4'b0010);
        req_en = '0;
        tick(1);
        req_en = 4'b1010;
        wait_resp(10, got, cyc);
        chk("t6_grant3", got, 4'b1000);
        chk("t6_arid3", last_arid, 0);
        chk("t6_addr3", last_araddr, 32'h2000_0008);
        req_en = 4'b0010;
        wait_resp(10, got, cyc);
        chk("t6_grant1", got, 4'b0010);
        chk("t6_arid1", last_arid, IDB + 1);
        req_en = '0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
